// File: rtl/adce_cal_seq.sv
// adce_cal_seq: round-robin calibrate/shutdown sequencer for the single-channel ADCE command port.
// Define ADCE_SEQ_WATCHDOG_EN to build the ADCE busy watchdog (chan_err / timeout).
module adce_cal_seq #(
  parameter int NUM_CHANNELS  = 5,
  parameter int CHAN_ADDR_W   = 3,
  parameter int SETTLE_CYCLES = 16,
  parameter int WD_CYCLES     = 1024
) (
  input  logic                    reconfig_clk,
  input  logic                    aclr,
  input  logic [NUM_CHANNELS-1:0] cal_req,
  input  logic [NUM_CHANNELS-1:0] sd_req,
  input  logic                    adce_busy,
  output logic                    adce_calibrate,
  output logic                    adce_shutdown,
  output logic                    adce_all_channels,
  output logic [CHAN_ADDR_W-1:0]  adce_chan,
  output logic                    seq_busy,
  output logic [NUM_CHANNELS-1:0] cal_done,
  output logic [NUM_CHANNELS-1:0] chan_err,
  output logic                    timeout
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACK, S_WAIT, S_SETTLE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] pend_cal, pend_sd, pend_any;
  logic [NUM_CHANNELS-1:0] cur_oh, nxt_oh, clr_cal, clr_sd;
  logic [CHAN_ADDR_W-1:0]  last_grant, cur_ch, nxt_ch, hi_ch, lo_ch;
  logic                    cur_sd, nxt_sd, hi_found, lo_found, grant;
  logic                    busy_done, wd_abort, wait_exit;
  logic [7:0]              settle_cnt;

  assign pend_any          = pend_cal | pend_sd;
  assign cur_oh            = NUM_CHANNELS'(1) << cur_ch;
  assign nxt_oh            = NUM_CHANNELS'(1) << nxt_ch;
  assign nxt_sd            = |(pend_sd & nxt_oh);
  assign adce_chan         = cur_ch;
  assign adce_all_channels = 1'b0;
  assign seq_busy          = (state_q != S_IDLE);
  assign busy_done         = (state_q == S_WAIT) && !adce_busy;
  assign wait_exit         = busy_done || wd_abort;
  assign clr_cal           = (state_q == S_ISSUE && !cur_sd) ? cur_oh : '0;
  assign clr_sd            = (state_q == S_ISSUE &&  cur_sd) ? cur_oh : '0;

  // Round-robin: lowest pending channel above last_grant, else lowest pending overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    for (int j = NUM_CHANNELS-1; j >= 0; j--) begin
      if (pend_any[j]) begin
        lo_ch    = CHAN_ADDR_W'(j);
        lo_found = 1'b1;
        if (CHAN_ADDR_W'(j) > last_grant) begin
          hi_ch    = CHAN_ADDR_W'(j);
          hi_found = 1'b1;
        end
      end
    end
    nxt_ch = hi_found ? hi_ch : lo_ch;
  end

  always_ff @(posedge reconfig_clk or posedge aclr) begin
    if (aclr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    adce_calibrate = 1'b0;
    adce_shutdown  = 1'b0;
    grant          = 1'b0;
    unique case (state_q)
      S_IDLE:   if (lo_found) begin
                  grant   = 1'b1;
                  state_d = S_ISSUE;
                end
      S_ISSUE:  begin
                  adce_calibrate = !cur_sd;
                  adce_shutdown  = cur_sd;
                  state_d        = S_ACK;
                end
      S_ACK:    state_d = S_WAIT;
      S_WAIT:   if (wait_exit) state_d = S_SETTLE;
      S_SETTLE: if (settle_cnt <= 8'd1) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A request landing in the same cycle as its grant clear is kept and re-run later.
  always_ff @(posedge reconfig_clk or posedge aclr) begin
    if (aclr) begin
      pend_cal   <= '0;
      pend_sd    <= '0;
      last_grant <= CHAN_ADDR_W'(NUM_CHANNELS-1);
      cur_ch     <= '0;
      cur_sd     <= 1'b0;
      settle_cnt <= '0;
      cal_done   <= '0;
    end else begin
      pend_cal <= (pend_cal & ~clr_cal) | cal_req;
      pend_sd  <= (pend_sd  & ~clr_sd)  | sd_req;
      if (grant) begin
        cur_ch     <= nxt_ch;
        cur_sd     <= nxt_sd;
        last_grant <= nxt_ch;
      end
      if (wait_exit)
        settle_cnt <= 8'(SETTLE_CYCLES);
      else if (state_q == S_SETTLE && settle_cnt != 8'd0)
        settle_cnt <= settle_cnt - 8'd1;
      cal_done <= (cal_done | ((busy_done && !cur_sd) ? cur_oh : '0)) & ~(cal_req | sd_req);
    end
  end

`ifdef ADCE_SEQ_WATCHDOG_EN
  logic [15:0] wd_cnt;

  // Normal completion wins if busy drops on the last watchdog cycle.
  assign wd_abort = (state_q == S_WAIT) && adce_busy && (wd_cnt <= 16'd1);

  always_ff @(posedge reconfig_clk or posedge aclr) begin
    if (aclr) begin
      wd_cnt   <= '0;
      chan_err <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state_q == S_ACK)
        wd_cnt <= 16'(WD_CYCLES);
      else if (state_q == S_WAIT && wd_cnt != 16'd0)
        wd_cnt <= wd_cnt - 16'd1;
      timeout  <= wd_abort;
      chan_err <= (chan_err | (wd_abort ? cur_oh : '0)) & ~cal_req;
    end
  end
`else
  assign wd_abort = 1'b0;
  assign chan_err = '0;
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_adce_cal_seq.sv
// Directed bench for adce_cal_seq with a simple ADCE busy responder.
module tb_adce_cal_seq;
  localparam int N = 5, AW = 3, SETTLE = 16, WD = 32;

  logic          reconfig_clk = 1'b0;
  logic          aclr = 1'b1;
  logic [N-1:0]  cal_req = '0, sd_req = '0;
  logic          adce_busy = 1'b0;
  logic          adce_calibrate, adce_shutdown, adce_all_channels, seq_busy, timeout;
  logic [AW-1:0] adce_chan;
  logic [N-1:0]  cal_done, chan_err;

  int   errors = 0, checks = 0, cyc = 0;
  int   busy_len = 1, busy_cnt = 0, n = 0, nev = 0;
  logic busy_stuck = 1'b0, both_seen = 1'b0;
  int   ev_chan[$], ev_cyc[$];
  logic ev_sd[$];

  adce_cal_seq #(.NUM_CHANNELS(N), .CHAN_ADDR_W(AW), .SETTLE_CYCLES(SETTLE), .WD_CYCLES(WD)) dut (
    .reconfig_clk(reconfig_clk), .aclr(aclr), .cal_req(cal_req), .sd_req(sd_req),
    .adce_busy(adce_busy), .adce_calibrate(adce_calibrate), .adce_shutdown(adce_shutdown),
    .adce_all_channels(adce_all_channels), .adce_chan(adce_chan), .seq_busy(seq_busy),
    .cal_done(cal_done), .chan_err(chan_err), .timeout(timeout));

  always #5 reconfig_clk = ~reconfig_clk;
  always @(posedge reconfig_clk) cyc <= cyc + 1;

  // ADCE model: busy for busy_len cycles from the command pulse, or held while busy_stuck.
  always @(negedge reconfig_clk) begin
    if (adce_calibrate || adce_shutdown) begin
      ev_chan.push_back(int'(adce_chan));
      ev_sd.push_back(adce_shutdown);
      ev_cyc.push_back(cyc);
      if (adce_calibrate && adce_shutdown) both_seen = 1'b1;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    adce_busy = busy_stuck || (busy_cnt > 0);
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge reconfig_clk);
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    tick(2);
    aclr = 1'b0;
    busy_cnt = 0;
    busy_stuck = 1'b0;
    ev_chan.delete(); ev_sd.delete(); ev_cyc.delete();
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_cal", adce_calibrate, 0);
    chk("rst_sd", adce_shutdown, 0);
    chk("rst_all", adce_all_channels, 0);
    chk("rst_chan", adce_chan, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_done", cal_done, 0);
    chk("rst_err", chan_err, 0);
    chk("rst_tmo", timeout, 0);
    aclr = 1'b0;

    // 1: single calibrate on ch2, ADCE busy 256 cycles
    busy_len = 256;
    cal_req = 5'b00100; tick(1); cal_req = '0; tick(1);
    chk("t1_cal", adce_calibrate, 1);
    chk("t1_sd", adce_shutdown, 0);
    chk("t1_chan", adce_chan, 2);
    chk("t1_busy", seq_busy, 1);
    n = 0;
    while (!cal_done[2] && n < 400) begin tick(1); n++; end
    chk("t1_done_lat", n, 257);          // busy low at ISSUE+256, done one cycle later
    chk("t1_done", cal_done, 5'b00100);
    chk("t1_chan_hold", adce_chan, 2);
    n = 0;
    while (seq_busy && n < 100) begin tick(1); n++; end
    chk("t1_idle_lat", n, SETTLE);       // SETTLE+1 after last WAIT cycle
    chk("t1_nev", ev_chan.size(), 1);

    // 2: all channels at once, minimum spacing
    do_reset();
    busy_len = 1;
    cal_req = 5'b11111; tick(1); cal_req = '0; tick(110);
    chk("t2_nev", ev_chan.size(), 5);
    for (int i = 0; i < ev_chan.size() && i < 5; i++) begin
      chk($sformatf("t2_order%0d", i), ev_chan[i], i);
      chk($sformatf("t2_type%0d", i), ev_sd[i], 0);
      if (i > 0) chk($sformatf("t2_gap%0d", i), ev_cyc[i] - ev_cyc[i-1], SETTLE + 4);
    end
    chk("t2_done", cal_done, 5'b11111);
    chk("t2_idle", seq_busy, 0);

    // 3: shutdown before calibrate on the same channel
    do_reset();
    sd_req = 5'b00010; cal_req = 5'b00010; tick(1); sd_req = '0; cal_req = '0; tick(1);
    chk("t3_sd", adce_shutdown, 1);
    chk("t3_sd_nocal", adce_calibrate, 0);
    chk("t3_sd_chan", adce_chan, 1);
    tick(SETTLE + 3);
    chk("t3_gap_cal", adce_calibrate, 0);
    chk("t3_gap_done", cal_done, 0);
    tick(1);
    chk("t3_cal", adce_calibrate, 1);
    chk("t3_cal_sd", adce_shutdown, 0);
    chk("t3_cal_chan", adce_chan, 1);
    tick(4);
    chk("t3_done", cal_done, 5'b00010);

    // 4: busy stuck on ch3, ch4 also pending
    do_reset();
    busy_len = 1; busy_stuck = 1'b1;
    cal_req = 5'b11000; tick(1); cal_req = '0; tick(1);
    chk("t4_cal", adce_calibrate, 1);
    chk("t4_chan", adce_chan, 3);
`ifdef ADCE_SEQ_WATCHDOG_EN
    tick(WD + 1);
    chk("t4_tmo_early", timeout, 0);
    tick(1);
    chk("t4_tmo", timeout, 1);
    chk("t4_err", chan_err, 5'b01000);
    chk("t4_nodone", cal_done, 0);
    busy_stuck = 1'b0;
    tick(1);
    chk("t4_tmo_pulse", timeout, 0);
    tick(SETTLE);
    chk("t4_next_cal", adce_calibrate, 1);
    chk("t4_next_chan", adce_chan, 4);
    tick(4);
    chk("t4_next_done", cal_done, 5'b10000);
    chk("t4_err_sticky", chan_err, 5'b01000);
`else
    tick(WD + 2);
    chk("t4_tmo", timeout, 0);
    chk("t4_err", chan_err, 0);
    chk("t4_still_busy", seq_busy, 1);
    chk("t4_chan_hold", adce_chan, 3);
    busy_stuck = 1'b0;
    n = 0;
    while (!cal_done[3] && n < 50) begin tick(1); n++; end
    chk("t4_done", cal_done, 5'b01000);
    n = 0;
    while (!adce_calibrate && n < 50) begin tick(1); n++; end
    chk("t4_next_cal", adce_calibrate, 1);
    chk("t4_next_chan", adce_chan, 4);
`endif

    // 5: cal_req[0] re-pulsed during its own ISSUE cycle
    do_reset();
    busy_len = 1;
    cal_req = 5'b00001; tick(1); cal_req = '0; tick(1);
    chk("t5_cal1", adce_calibrate, 1);
    chk("t5_chan1", adce_chan, 0);
    cal_req = 5'b00001; tick(1); cal_req = '0;
    tick(SETTLE + 3);
    chk("t5_cal2", adce_calibrate, 1);
    chk("t5_chan2", adce_chan, 0);
    tick(25);
    chk("t5_done", cal_done, 5'b00001);
    chk("t5_nev", ev_chan.size(), 2);
    chk("t5_idle", seq_busy, 0);

    // 6: aclr during WAIT drops everything, including the queued ch2
    do_reset();
    busy_len = 256;
    cal_req = 5'b00110; tick(1); cal_req = '0; tick(1);
    chk("t6_cal", adce_calibrate, 1);
    chk("t6_chan", adce_chan, 1);
    tick(10);
    chk("t6_in_wait", seq_busy, 1);
    aclr = 1'b1;
    #1;
    chk("t6_rst_busy", seq_busy, 0);
    chk("t6_rst_chan", adce_chan, 0);
    chk("t6_rst_cal", adce_calibrate, 0);
    chk("t6_rst_sd", adce_shutdown, 0);
    chk("t6_rst_done", cal_done, 0);
    chk("t6_rst_err", chan_err, 0);
    chk("t6_rst_tmo", timeout, 0);
    nev = ev_chan.size();
    tick(2);
    aclr = 1'b0;
    tick(60);
    chk("t6_no_pulse", ev_chan.size(), nev);
    chk("t6_idle", seq_busy, 0);

    chk("never_both", both_seen, 0);
    chk("all_ch_tie", adce_all_channels, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
